tensor_stream_tx: RTL and testbench

AXI4-Stream transmitter that reads a contiguous tensor from a local buffer, such as a host-side staging SRAM or the NPU result SRAM, and streams it as one packet. It drives the NPU's slave tensor-load port: 8-bit `tdata`, per-packet metadata on `tuser`, and `tlast` on the final byte. It is the sending end of the same stream protocol the NPU's input stage receives. The block uses a synchronous read port with 1-cycle latency and a 2-entry output buffer, so it sustains 1 beat/cycle under full `tready`.

---
 rtl/tensor_stream_tx.sv | 190 +++++++++++++++++++
 tb/tb_tensor_stream_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tensor_stream_tx.sv
// ============================================================================
// Module      : tensor_stream_tx
// Description : AXI4-Stream transmitter. Reads a contiguous tensor from a
//               buffer with a 1-cycle synchronous read port and sends it as
//               one packet, with per-packet metadata on tuser and tlast on
//               the final byte. A 2-entry output FIFO plus a bypass of the
//               in-flight read keeps 1 beat/cycle under full tready.
//               Optional macro TX_STALL_CNT_EN enables the saturating
//               backpressure counter on stall_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tensor_stream_tx #(
  parameter int ADDR_WIDTH         = 13,
  parameter int MAX_ADDR_WIDTH     = 18,
  parameter int DATA_WIDTH         = 8,
  parameter int NUM_CHANNELS_WIDTH = 7
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [MAX_ADDR_WIDTH-1:0]                   tx_base,
  input  logic [MAX_ADDR_WIDTH-1:0]                   tx_len,
  input  logic [ADDR_WIDTH-1:0]                       tx_dim0,
  input  logic [ADDR_WIDTH-1:0]                       tx_dim1,
  input  logic [ADDR_WIDTH-1:0]                       tx_dim2,
  input  logic [ADDR_WIDTH-1:0]                       tx_dim3,
  input  logic [NUM_CHANNELS_WIDTH-1:0]               tx_channels,
  output logic                                        mem_en,
  output logic [MAX_ADDR_WIDTH-1:0]                   mem_addr,
  input  logic [DATA_WIDTH-1:0]                       mem_rdata,
  output logic [DATA_WIDTH-1:0]                       m_axis_tdata,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic                                        m_axis_tlast,
  output logic [4*ADDR_WIDTH+NUM_CHANNELS_WIDTH-1:0]  m_axis_tuser,
  output logic                                        busy,
  output logic                                        done,
  output logic [31:0]                                 stall_count
);

  localparam int c_TUSER_WIDTH = 4*ADDR_WIDTH + NUM_CHANNELS_WIDTH;
  localparam logic [MAX_ADDR_WIDTH-1:0] c_ONE = {{(MAX_ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t                    r_state;
  logic [MAX_ADDR_WIDTH-1:0] r_len;
  logic [MAX_ADDR_WIDTH-1:0] r_addr;
  logic [MAX_ADDR_WIDTH-1:0] r_issued;
  logic [MAX_ADDR_WIDTH-1:0] r_beat;
  logic [c_TUSER_WIDTH-1:0]  r_tuser;
  logic                      r_inflight;   // read issued last cycle; its data is on mem_rdata now

  logic [DATA_WIDTH-1:0]     r_fifo [2];
  logic                      r_rd_ptr;
  logic                      r_wr_ptr;
  logic [1:0]                r_count;

  logic                      w_tvalid;
  logic                      w_pop;
  logic                      w_last;
  logic                      w_issue;
  logic                      w_push;
  logic                      w_fifo_pop;
  logic [2:0]                w_occ;
  logic [2:0]                w_occ_after;
  logic [DATA_WIDTH-1:0]     w_head;

  // The in-flight read counts as a queued entry so the first beat can be
  // presented straight from mem_rdata the cycle it arrives.
  assign w_tvalid    = (r_state == ST_STREAM) && ((r_count != 2'd0) || r_inflight);
  assign w_pop       = w_tvalid && m_axis_tready;
  assign w_last      = (r_beat == (r_len - c_ONE));
  assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_occ_after = w_occ - {2'b00, w_pop};
  assign w_issue     = (r_state == ST_STREAM) && (r_issued < r_len) && (w_occ_after <= 3'd1);
  assign w_fifo_pop  = w_pop && (r_count != 2'd0);
  // Arriving data is stored unless it is consumed directly through the bypass.
  assign w_push      = r_inflight && !(w_pop && (r_count == 2'd0));
  assign w_head      = (r_count != 2'd0) ? r_fifo[r_rd_ptr] : mem_rdata;

  // Transfer FSM: launch, address generation, beat counting and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_addr     <= '0;
      r_issued   <= '0;
      r_beat     <= '0;
      r_tuser    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len    <= tx_len;
            r_addr   <= tx_base;
            r_issued <= '0;
            r_beat   <= '0;
            r_tuser  <= {tx_channels, tx_dim3, tx_dim2, tx_dim1, tx_dim0};
            r_state  <= (tx_len == '0) ? ST_FINISH : ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_issue) begin
            r_addr   <= r_addr + c_ONE;
            r_issued <= r_issued + c_ONE;
          end
          if (w_pop) begin
            r_beat <= r_beat + c_ONE;
            if (w_last) begin
              r_state <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          r_tuser <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping; reset empties the queue and drops in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_fifo_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_fifo_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful where r_count says so.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= mem_rdata;
    end
  end

  assign mem_en        = w_issue;
  assign mem_addr      = r_addr;
  assign m_axis_tvalid = w_tvalid;
  assign m_axis_tdata  = w_tvalid ? w_head : '0;
  assign m_axis_tlast  = w_tvalid && w_last;
  assign m_axis_tuser  = r_tuser;
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_FINISH);

`ifdef TX_STALL_CNT_EN
  logic [31:0] r_stall_count;

  // Saturating count of cycles where a beat was offered but not taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= 32'd0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_stall_count <= 32'd0;
    end else if (w_tvalid && !m_axis_tready && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tensor_stream_tx.sv
// ============================================================================
// Module      : tb_tensor_stream_tx
// Description : Directed self-checking bench for tensor_stream_tx with a
//               1-cycle synchronous buffer model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tensor_stream_tx;

  localparam int AW  = 13;
  localparam int MAW = 18;
  localparam int DW  = 8;
  localparam int CW  = 7;
  localparam int UW  = 4*AW + CW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [MAW-1:0] tx_base = '0;
  logic [MAW-1:0] tx_len = '0;
  logic [AW-1:0]  tx_dim0 = '0;
  logic [AW-1:0]  tx_dim1 = '0;
  logic [AW-1:0]  tx_dim2 = '0;
  logic [AW-1:0]  tx_dim3 = '0;
  logic [CW-1:0]  tx_channels = '0;
  logic           mem_en;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0]  mem_rdata = '0;
  logic [DW-1:0]  m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready = 1'b1;
  logic           m_axis_tlast;
  logic [UW-1:0]  m_axis_tuser;
  logic           busy;
  logic           done;
  logic [31:0]    stall_count;

  logic [7:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  tensor_stream_tx dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .tx_base       (tx_base),
    .tx_len        (tx_len),
    .tx_dim0       (tx_dim0),
    .tx_dim1       (tx_dim1),
    .tx_dim2       (tx_dim2),
    .tx_dim3       (tx_dim3),
    .tx_channels   (tx_channels),
    .mem_en        (mem_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .busy          (busy),
    .done          (done),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  // Synchronous buffer: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr[9:0]];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #2;
  endtask

  function automatic logic [UW-1:0] pack_user(input int d0, input int d1, input int d2,
                                               input int d3, input int ch);
    return {CW'(ch), AW'(d3), AW'(d2), AW'(d1), AW'(d0)};
  endfunction

  task automatic launch(input int base, input int len, input int d0, input int d1,
                        input int d2, input int d3, input int ch);
    start       = 1'b1;
    tx_base     = MAW'(base);
    tx_len      = MAW'(len);
    tx_dim0     = AW'(d0);
    tx_dim1     = AW'(d1);
    tx_dim2     = AW'(d2);
    tx_dim3     = AW'(d3);
    tx_channels = CW'(ch);
  endtask

  logic [7:0] nom_data [4];
  logic [7:0] bp_data  [6];
  logic [UW-1:0] exp_user;
  int occ;
  int got;
  int stalls;
  logic prev_stall;
  logic [7:0] prev_data;
  logic seen_done;
  logic seen_tlast;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[10'h010] = 8'h11; mem[10'h011] = 8'h22; mem[10'h012] = 8'h33; mem[10'h013] = 8'h44;
    for (int i = 0; i < 6; i++) mem[10'h040 + i] = 8'hA0 + 8'(i);
    for (int i = 0; i < 8; i++) mem[10'h080 + i] = 8'hC0 + 8'(i);
    nom_data[0] = 8'h11; nom_data[1] = 8'h22; nom_data[2] = 8'h33; nom_data[3] = 8'h44;
    for (int i = 0; i < 6; i++) bp_data[i] = 8'hA0 + 8'(i);

    // ---------------- reset state
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    sample();
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast",  64'(m_axis_tlast),  64'd0);
    check("rst_mem_en", 64'(mem_en),        64'd0);
    check("rst_busy",   64'(busy),          64'd0);
    check("rst_done",   64'(done),          64'd0);
    check("rst_tdata",  64'(m_axis_tdata),  64'd0);
    check("rst_tuser",  64'(m_axis_tuser),  64'd0);
    check("rst_addr",   64'(mem_addr),      64'd0);
    check("rst_stall",  64'(stall_count),   64'd0);

    // ---------------- nominal: base 0x10, len 4, full tready
    step();
    launch(16, 4, 1, 2, 3, 4, 5);
    m_axis_tready = 1'b1;
    exp_user = pack_user(1, 2, 3, 4, 5);
    sample();
    check("nom_c0_busy", 64'(busy), 64'd0);
    step(); start = 1'b0; sample();                       // cycle 1
    check("nom_c1_mem_en", 64'(mem_en), 64'd1);
    check("nom_c1_addr",   64'(mem_addr), 64'h10);
    check("nom_c1_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("nom_c1_busy",   64'(busy), 64'd1);
    for (int k = 0; k < 4; k++) begin                      // cycles 2..5
      step(); sample();
      check("nom_tvalid", 64'(m_axis_tvalid), 64'd1);
      check("nom_tdata",  64'(m_axis_tdata),  64'(nom_data[k]));
      check("nom_tlast",  64'(m_axis_tlast),  (k == 3) ? 64'd1 : 64'd0);
      check("nom_tuser",  64'(m_axis_tuser),  64'(exp_user));
      check("nom_mem_en", 64'(mem_en),        (k < 3) ? 64'd1 : 64'd0);
      if (k < 3) check("nom_addr", 64'(mem_addr), 64'h11 + 64'(k));
      check("nom_done_early", 64'(done), 64'd0);
    end
    step(); sample();                                      // cycle 6
    check("nom_c6_done",   64'(done), 64'd1);
    check("nom_c6_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("nom_c6_busy",   64'(busy), 64'd1);
    step(); sample();                                      // cycle 7
    check("nom_c7_done",  64'(done), 64'd0);
    check("nom_c7_busy",  64'(busy), 64'd0);
    check("nom_c7_tuser", 64'(m_axis_tuser), 64'd0);
    check("nom_stall",    64'(stall_count), 64'd0);

    // ---------------- backpressure: base 0x40, len 6, tready 1,0,0,...
    step();
    launch(64, 6, 0, 0, 0, 0, 0);
    sample();
    step(); start = 1'b0;
    occ = 0; got = 0; stalls = 0; prev_stall = 1'b0; prev_data = '0;
    seen_done = 1'b0;
    for (int c = 1; c < 80 && !seen_done; c++) begin
      m_axis_tready = (c % 3 == 2);
      sample();
      if (mem_en) check("bp_mem_en_room", 64'((occ - int'(m_axis_tvalid && m_axis_tready)) <= 1), 64'd1);
      if (prev_stall) check("bp_hold", 64'(m_axis_tdata), 64'(prev_data));
      if (m_axis_tvalid && m_axis_tready) begin
        if (got < 6) check("bp_tdata", 64'(m_axis_tdata), 64'(bp_data[got]));
        check("bp_tlast", 64'(m_axis_tlast), (got == 5) ? 64'd1 : 64'd0);
        got++;
      end
      if (m_axis_tvalid && !m_axis_tready) stalls++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      occ = occ + int'(mem_en) - int'(m_axis_tvalid && m_axis_tready);
      if (done) seen_done = 1'b1;
      step();
    end
    m_axis_tready = 1'b1;
    check("bp_done_seen", 64'(seen_done), 64'd1);
    check("bp_beats",     64'(got), 64'd6);
`ifdef TX_STALL_CNT_EN
    check("bp_stall_count", 64'(stall_count), 64'(stalls));
`else
    check("bp_stall_count", 64'(stall_count), 64'd0);
`endif

    // ---------------- zero length
    launch(32, 0, 0, 0, 0, 0, 0);
    sample();
    check("zl_c0_mem_en", 64'(mem_en), 64'd0);
    step(); start = 1'b0; sample();                        // cycle 1
    check("zl_c1_done",   64'(done), 64'd1);
    check("zl_c1_mem_en", 64'(mem_en), 64'd0);
    check("zl_c1_tvalid", 64'(m_axis_tvalid), 64'd0);
    step(); sample();                                      // cycle 2
    check("zl_c2_done", 64'(done), 64'd0);
    check("zl_c2_busy", 64'(busy), 64'd0);

    // ---------------- metadata, with an ignored start mid-packet
    step();
    launch(16, 3, 28, 28, 3, 3, 1);
    exp_user = pack_user(28, 28, 3, 3, 1);
    sample();
    step();                                                // cycle 1: try to relaunch
    launch(64, 6, 7, 7, 7, 7, 9);
    sample();
    check("md_c1_addr", 64'(mem_addr), 64'h10);
    for (int k = 0; k < 3; k++) begin                      // cycles 2..4
      step(); start = 1'b0; sample();
      check("md_tdata", 64'(m_axis_tdata), 64'(nom_data[k]));
      check("md_tuser", 64'(m_axis_tuser), 64'(exp_user));
      check("md_tlast", 64'(m_axis_tlast), (k == 2) ? 64'd1 : 64'd0);
    end
    step(); sample();                                      // cycle 5
    check("md_done", 64'(done), 64'd1);
    step(); sample();
    check("md_tuser_idle", 64'(m_axis_tuser), 64'd0);
    check("md_busy_idle",  64'(busy), 64'd0);

    // ---------------- reset mid-packet: len 8, reset while beat 3 is presented
    step();
    launch(128, 8, 0, 0, 0, 0, 0);
    sample();
    step(); start = 1'b0; sample();                        // cycle 1
    step(); step(); step(); sample();                      // cycle 4 shows beat 2
    check("rm_beat2", 64'(m_axis_tdata), 64'hC2);
    step();                                                // cycle 5 shows beat 3
    rst = 1'b1;
    sample();
    check("rm_beat3", 64'(m_axis_tdata), 64'hC3);
    step(); rst = 1'b0; sample();                          // cycle 6
    check("rm_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rm_tlast",  64'(m_axis_tlast), 64'd0);
    check("rm_done",   64'(done), 64'd0);
    check("rm_busy",   64'(busy), 64'd0);
    step(); sample();
    check("rm_done_later", 64'(done), 64'd0);
    check("rm_tvalid_later", 64'(m_axis_tvalid), 64'd0);

    launch(16, 2, 0, 0, 0, 0, 0);
    sample();
    step(); start = 1'b0; sample();                        // cycle 1
    check("rm2_addr", 64'(mem_addr), 64'h10);
    step(); sample();                                      // cycle 2
    check("rm2_b0", 64'(m_axis_tdata), 64'h11);
    check("rm2_b0_last", 64'(m_axis_tlast), 64'd0);
    step(); sample();                                      // cycle 3
    check("rm2_b1", 64'(m_axis_tdata), 64'h22);
    check("rm2_b1_last", 64'(m_axis_tlast), 64'd1);
    step(); sample();                                      // cycle 4
    check("rm2_done", 64'(done), 64'd1);

    // ---------------- single beat: base 0x13, len 1
    step(); sample();
    launch(19, 1, 0, 0, 0, 0, 0);
    sample();
    step(); start = 1'b0; sample();                        // cycle 1
    check("sb_c1_mem_en", 64'(mem_en), 64'd1);
    step(); sample();                                      // cycle 2
    check("sb_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("sb_tdata",  64'(m_axis_tdata), 64'h44);
    check("sb_tlast",  64'(m_axis_tlast), 64'd1);
    check("sb_c2_mem_en", 64'(mem_en), 64'd0);
    step(); sample();                                      // cycle 3
    check("sb_done",   64'(done), 64'd1);
    check("sb_tvalid_after", 64'(m_axis_tvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
